processador_multiciclo_param: RTL and testbench
===============================================

Name: processador_multiciclo_param

Overview:
Parametrised successor of the team's multicycle processor, generalised in data width, register count and memory address width. It adds an external synchronous-memory port, a zero flag with conditional move (mvnz), an AND operation, an illegal-opcode flag and an instruction counter. A Moore FSM sequences fetch, memory wait, IR load and up to three execute steps. It sits between the board-level wrapper and a single-port synchronous RAM (1-cycle read latency).

Parameters:
DATA_W, 16, width of registers, ALU, bus and memory data
SEL_W, 3, register select width; NREGS = 2**SEL_W, and R[NREGS-1] is the PC
ADDR_W, 6, memory address width; mem_addr = low ADDR_W bits of the PC or ADDR register
(derived) IR_W = 4 + 2*SEL_W; DATA_W >= IR_W is required

Ports:
Clock  in  1  single clock, rising edge
Resetn  in  1  asynchronous, active-low reset
Run  in  1  enables instruction fetch
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after the address is registered
mem_addr  out  ADDR_W  registered memory address (ADDR register)
mem_wdata  out  DATA_W  registered write data (DOUT register)
mem_wren  out  1  write strobe
BusWires  out  DATA_W  internal bus value (debug)
Done  out  1  high during the final execute cycle of each instruction
Tstep  out  3  current FSM state encoding (debug)
pc  out  DATA_W  current PC value
instr_count  out  16  count of retired instructions; wraps modulo 2^16
illegal  out  1  sticky flag; set when an undefined opcode executes

Behaviour:
- Reset (async, Resetn=0): all Rn, A, G, IR, ADDR, DOUT, instr_count and illegal are 0; Z is 1; state is IDLE; mem_wren, Done and Tstep are 0 immediately, including mid-instruction.
- IR fields: op = IR[IR_W-1:2*SEL_W]; Rx = IR[2*SEL_W-1:SEL_W]; Ry = IR[SEL_W-1:0]. IR loads mem_rdata[IR_W-1:0].
- FSM state encodings: IDLE=0, FETCH=1, WAIT=2, LDIR=3, EX1=4, EX2=5, EX3=6.
- IDLE: if Run=1, go to FETCH.
- FETCH: ADDR<=PC; PC<=PC+1.
- WAIT: no register updates.
- LDIR: IR<=mem_rdata.
- Opcode execution (Done asserted in the listed final cycle):
  - 0000 mv: EX1 Rx<=Ry; Done.
  - 0001 mvi: EX1 ADDR<=PC, PC<=PC+1; EX2 wait; EX3 Rx<=mem_rdata; Done.
  - 0010 add / 0011 sub / 0111 and: EX1 A<=Rx; EX2 G<=A op Ry (modulo 2^DATA_W), Z<=(result==0); EX3 Rx<=G; Done.
  - 0100 ld: EX1 ADDR<=Ry; EX2 wait; EX3 Rx<=mem_rdata; Done.
  - 0101 st: EX1 ADDR<=Ry, DOUT<=Rx; EX2 mem_wren=1 for exactly one cycle; Done.
  - 0110 mvnz: EX1 Rx<=Ry only if Z=0; Done in either case.
  - Any other opcode: EX1 no architectural change except illegal<=1; Done.
- Cycle counts per instruction: mv/mvnz/illegal 4; st 5; mvi/ld/alu 6.
- On the Done cycle: instr_count increments. Next state is FETCH if Run=1, else IDLE. Run is ignored mid-instruction.
- Writing Rx = PC (mv, mvi, ld, alu) is a jump. PC never increments in the same cycle as a PC write.
- BusWires shows the value driven in that cycle (Ry, Rx, G, mem_rdata or PC); otherwise 0.
- mem_wren is 0 in every state except st EX2.

Test Plan:
- Reset, memory {0x040, 0x0005, 0x048, 0x0003, 0x081}, Run=1 -> after 3 Done pulses R0=8, R1=3, pc=5, instr_count=3; cycle gaps between Done pulses are 6, 6, 6.
- mvi R0,#0; mvi R1,#1; sub R0,R1 (0x0C1) -> R0=0xFFFF, Z=0; then mvnz R2,R1 (0x191) -> R2=1.
- mvi R3,#0x0020; mvi R4,#0xABCD; st R4,[R3] (0x163) -> mem_wren high for exactly 1 cycle, mem_addr=0x20, mem_wdata=0xABCD; ld R5,[R3] (0x12B) -> R5=0xABCD.
- Opcode 0xF word (0x3C0) -> Done after 4 cycles, illegal=1 and stays 1; no register changes.
- Resetn pulsed low during st EX1 -> mem_wren is never asserted, all outputs 0, pc=0; after release, execution restarts from address 0.
- Run=0 while an alu instruction is mid-execution -> the instruction completes (Done), the FSM goes to IDLE, and pc is unchanged until Run=1.

Source files
------------

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor with an external synchronous memory port.
// One shared bus carries Ry, Rx, G, mem_rdata or the PC, and the FSM selects which
// one each cycle. The register file holds NREGS words, and the top register is the PC.
//
// The instruction must fit in a data word, so DATA_W >= 4 + 2*SEL_W is required.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Run
// FETCH | ADDR <= PC, PC <= PC+1
// WAIT  | synchronous RAM read in flight
// LDIR  | IR <= mem_rdata
// EX1   | first execute step (mv/mvnz/illegal finish here)
// EX2   | second execute step (st finishes here with the write strobe)
// EX3   | third execute step (mvi/ld/alu write back Rx)
module processador_multiciclo_param #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int ADDR_W = 6
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic [DATA_W-1:0] BusWires,
    output logic              Done,
    output logic [2:0]        Tstep,
    output logic [DATA_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              illegal
);

    localparam int NREGS  = 2 ** SEL_W;
    localparam int IR_W   = 4 + 2 * SEL_W;
    localparam int PC_IDX = NREGS - 1;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_MVNZ = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LDIR  = 3'd3,
        S_EX1   = 3'd4,
        S_EX2   = 3'd5,
        S_EX3   = 3'd6
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_g;
    logic [IR_W-1:0]   ir;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              z;

    logic [3:0]        op;
    logic [SEL_W-1:0]  rx;
    logic [SEL_W-1:0]  ry;
    logic [DATA_W-1:0] rx_val;
    logic [DATA_W-1:0] ry_val;
    logic [DATA_W-1:0] pc_val;
    logic [DATA_W-1:0] alu_res;

    // control strobes produced by the FSM decoder
    logic              bus_en;
    logic [DATA_W-1:0] bus;
    logic              rx_wr;
    logic              pc_inc;
    logic              addr_ld;
    logic              dout_ld;
    logic              a_ld;
    logic              g_ld;
    logic              ir_ld;
    logic              ill_set;
    logic              done;
    logic              wren;

    assign op     = ir[IR_W-1:2*SEL_W];
    assign rx     = ir[2*SEL_W-1:SEL_W];
    assign ry     = ir[SEL_W-1:0];
    assign rx_val = regs[rx];
    assign ry_val = regs[ry];
    assign pc_val = regs[PC_IDX];

    // ALU for add/sub/and; the result wraps modulo 2**DATA_W
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = reg_a + ry_val;
            OP_SUB:  alu_res = reg_a - ry_val;
            OP_AND:  alu_res = reg_a & ry_val;
            default: alu_res = '0;
        endcase
    end

    // state register; reset forces IDLE so Done/mem_wren drop at once
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode and per-cycle control strobes
    always_comb begin
        state_next = state;
        bus_en     = 1'b0;
        bus        = '0;
        rx_wr      = 1'b0;
        pc_inc     = 1'b0;
        addr_ld    = 1'b0;
        dout_ld    = 1'b0;
        a_ld       = 1'b0;
        g_ld       = 1'b0;
        ir_ld      = 1'b0;
        ill_set    = 1'b0;
        done       = 1'b0;
        wren       = 1'b0;

        case (state)
            S_IDLE: begin
                if (Run) state_next = S_FETCH;
            end
            S_FETCH: begin
                bus_en     = 1'b1;
                bus        = pc_val;
                addr_ld    = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                state_next = S_LDIR;
            end
            S_LDIR: begin
                bus_en     = 1'b1;
                bus        = mem_rdata;
                ir_ld      = 1'b1;
                state_next = S_EX1;
            end
            S_EX1: begin
                case (op)
                    OP_MV: begin
                        bus_en = 1'b1;
                        bus    = ry_val;
                        rx_wr  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_MVI: begin
                        bus_en     = 1'b1;
                        bus        = pc_val;
                        addr_ld    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = S_EX2;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_en     = 1'b1;
                        bus        = rx_val;
                        a_ld       = 1'b1;
                        state_next = S_EX2;
                    end
                    OP_LD: begin
                        bus_en     = 1'b1;
                        bus        = ry_val;
                        addr_ld    = 1'b1;
                        state_next = S_EX2;
                    end
                    OP_ST: begin
                        // address travels on the bus, data goes straight from Rx to DOUT
                        bus_en     = 1'b1;
                        bus        = ry_val;
                        addr_ld    = 1'b1;
                        dout_ld    = 1'b1;
                        state_next = S_EX2;
                    end
                    OP_MVNZ: begin
                        bus_en = 1'b1;
                        bus    = ry_val;
                        rx_wr  = ~z;
                        done   = 1'b1;
                    end
                    default: begin
                        ill_set = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            S_EX2: begin
                case (op)
                    OP_MVI, OP_LD: begin
                        state_next = S_EX3;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_en     = 1'b1;
                        bus        = ry_val;
                        g_ld       = 1'b1;
                        state_next = S_EX3;
                    end
                    OP_ST: begin
                        wren = 1'b1;
                        done = 1'b1;
                    end
                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end
            S_EX3: begin
                case (op)
                    OP_MVI, OP_LD: begin
                        bus_en = 1'b1;
                        bus    = mem_rdata;
                        rx_wr  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_en = 1'b1;
                        bus    = reg_g;
                        rx_wr  = 1'b1;
                        done   = 1'b1;
                    end
                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Run is only sampled between instructions
        if (done) state_next = Run ? S_FETCH : S_IDLE;
    end

    // register file; an Rx write to the PC overrides the increment (never both in one cycle)
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (pc_inc) regs[PC_IDX] <= pc_val + DATA_W'(1);
            if (rx_wr)  regs[rx]     <= bus;
        end
    end

    // datapath registers: A, G, Z, IR, ADDR, DOUT
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            reg_a    <= '0;
            reg_g    <= '0;
            z        <= 1'b1;
            ir       <= '0;
            addr_reg <= '0;
            dout_reg <= '0;
        end else begin
            if (a_ld) reg_a <= bus;
            if (g_ld) begin
                reg_g <= alu_res;
                z     <= (alu_res == '0);
            end
            if (ir_ld)   ir       <= mem_rdata[IR_W-1:0];
            if (addr_ld) addr_reg <= bus[ADDR_W-1:0];
            if (dout_ld) dout_reg <= rx_val;
        end
    end

    // retired-instruction counter and sticky illegal-opcode flag
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            if (done)    instr_count <= instr_count + 16'd1;
            if (ill_set) illegal     <= 1'b1;
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = dout_reg;
    assign mem_wren  = wren;
    assign BusWires  = bus_en ? bus : '0;
    assign Done      = done;
    assign Tstep     = state;
    assign pc        = pc_val;

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Bench for processador_multiciclo_param: small programs in a behavioural
// synchronous RAM, each checked against hand-computed architectural results.
module tb_processador_multiciclo_param;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [15:0] mem_rdata;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wren;
    logic [15:0] BusWires;
    logic        Done;
    logic [2:0]  Tstep;
    logic [15:0] pc;
    logic [15:0] instr_count;
    logic        illegal;

    processador_multiciclo_param #(.DATA_W(16), .SEL_W(3), .ADDR_W(6)) dut (
        .Clock(clk), .Resetn(Resetn), .Run(Run), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .BusWires(BusWires), .Done(Done), .Tstep(Tstep), .pc(pc),
        .instr_count(instr_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // synchronous RAM, 1-cycle read latency, image loaded on request
    logic [15:0] mem [64];
    logic [15:0] load_img [64];
    logic        load_req = 1'b0;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] = load_img[i];
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_wren) mem[mem_addr] = mem_wdata;
        end
    end

    // monitor sampled just after each rising edge
    int          cyc = 0;
    int          done_cnt = 0;
    int          wren_cnt = 0;
    int          last_done = 0;
    int          gaps [16];
    logic [5:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clr_req = 1'b0;
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (clr_req) begin
            done_cnt  = 0;
            wren_cnt  = 0;
            last_done = cyc - 1;
        end
        if (Done) begin
            if (done_cnt < 16) gaps[done_cnt] = cyc - last_done;
            last_done = cyc;
            done_cnt  = done_cnt + 1;
        end
        if (mem_wren) begin
            wren_cnt = wren_cnt + 1;
            wr_addr  = mem_addr;
            wr_data  = mem_wdata;
        end
    end

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef logic [7:0][15:0] prog_t;

    typedef struct {
        string       name;
        prog_t       prog;
        int          n_instr;
        int          ra;
        logic [15:0] va;
        int          rb;
        logic [15:0] vb;
        logic [15:0] pc;
        logic        z;
        logic        ill;
        int          wren;
        int          gap;
    } vec_t;

    vec_t vecs [7];

    function automatic prog_t p8(input logic [15:0] a, b, c, d, e, f);
        prog_t p;
        p = '0;
        p[0] = a; p[1] = b; p[2] = c; p[3] = d; p[4] = e; p[5] = f;
        return p;
    endfunction

    task automatic do_reset(input prog_t p);
        Resetn = 1'b0;
        Run    = 1'b0;
        for (int i = 0; i < 64; i++) load_img[i] = (i < 8) ? p[i] : 16'h0000;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
        Resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        Run     = 1'b1;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n, input bit drop);
        int b = 0;
        while (done_cnt < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk({name, "_done_reached"}, 32'(done_cnt >= n), 32'd1);
        if (drop) Run = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] st);
        int b = 0;
        while (Tstep !== st && b < 40) begin
            @(negedge clk);
            b++;
        end
        chk({name, "_state_reached"}, 32'(Tstep), 32'(st));
    endtask

    task automatic run_vec(input vec_t v);
        do_reset(v.prog);
        start_run();
        wait_done(v.name, v.n_instr, 1'b1);
        repeat (3) @(negedge clk);
        chk({v.name, "_ra"}, 32'(dut.regs[v.ra]), 32'(v.va));
        chk({v.name, "_rb"}, 32'(dut.regs[v.rb]), 32'(v.vb));
        chk({v.name, "_pc"}, 32'(pc), 32'(v.pc));
        chk({v.name, "_count"}, 32'(instr_count), 32'(v.n_instr));
        chk({v.name, "_z"}, 32'(dut.z), 32'(v.z));
        chk({v.name, "_illegal"}, 32'(illegal), 32'(v.ill));
        chk({v.name, "_wren_cycles"}, 32'(wren_cnt), 32'(v.wren));
        chk({v.name, "_last_gap"}, 32'(gaps[v.n_instr-1]), 32'(v.gap));
    endtask

    task automatic set_vec(input int i, input string nm, input prog_t p, input int n,
                           input int ra, input logic [15:0] va, input int rb, input logic [15:0] vb,
                           input logic [15:0] epc, input logic ez, input logic eill,
                           input int ew, input int eg);
        vecs[i].name = nm;  vecs[i].prog = p;  vecs[i].n_instr = n;
        vecs[i].ra = ra;    vecs[i].va = va;   vecs[i].rb = rb;  vecs[i].vb = vb;
        vecs[i].pc = epc;   vecs[i].z = ez;    vecs[i].ill = eill;
        vecs[i].wren = ew;  vecs[i].gap = eg;
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;

        set_vec(0, "mvi_add", p8(16'h040, 16'h0005, 16'h048, 16'h0003, 16'h081, 16'h0),
                3, 0, 16'h0008, 1, 16'h0003, 16'd5, 1'b0, 1'b0, 0, 6);
        set_vec(1, "sub_mvnz", p8(16'h040, 16'h0000, 16'h048, 16'h0001, 16'h0C1, 16'h191),
                4, 0, 16'hFFFF, 2, 16'h0001, 16'd6, 1'b0, 1'b0, 0, 4);
        set_vec(2, "st_ld", p8(16'h058, 16'h0020, 16'h060, 16'hABCD, 16'h163, 16'h12B),
                4, 5, 16'hABCD, 4, 16'hABCD, 16'd6, 1'b1, 1'b0, 1, 6);
        set_vec(3, "illegal", p8(16'h3C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
                1, 0, 16'h0000, 1, 16'h0000, 16'd1, 1'b1, 1'b1, 0, 4);
        set_vec(4, "and_zero_mvnz", p8(16'h040, 16'h00F0, 16'h048, 16'h0F0F, 16'h1C1, 16'h190),
                4, 0, 16'h0000, 2, 16'h0000, 16'd6, 1'b1, 1'b0, 0, 4);
        set_vec(5, "jump_mv_pc", p8(16'h078, 16'h0004, 16'h0, 16'h0, 16'h00F, 16'h0),
                2, 1, 16'h0005, 0, 16'h0000, 16'd5, 1'b1, 1'b0, 0, 4);
        set_vec(6, "add_wrap", p8(16'h040, 16'hFFFF, 16'h048, 16'h0001, 16'h081, 16'h0),
                3, 0, 16'h0000, 1, 16'h0001, 16'd5, 1'b1, 1'b0, 0, 6);

        // reset state
        do_reset(vecs[0].prog);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_tstep", 32'(Tstep), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_bus", 32'(BusWires), 32'd0);
        chk("rst_z", 32'(dut.z), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Done spacing for the three-instruction program
        run_vec(vecs[0]);
        chk("gap0", 32'(gaps[0]), 32'd6);
        chk("gap1", 32'(gaps[1]), 32'd6);

        // store: single-cycle strobe with the right address and data
        run_vec(vecs[2]);
        chk("st_addr", 32'(wr_addr), 32'h20);
        chk("st_data", 32'(wr_data), 32'hABCD);
        chk("st_mem", 32'(mem[32]), 32'hABCD);

        // illegal flag is sticky across a following legal instruction
        do_reset(p8(16'h3C0, 16'h000, 16'h0, 16'h0, 16'h0, 16'h0));
        start_run();
        wait_done("sticky", 2, 1'b1);
        repeat (3) @(negedge clk);
        chk("sticky_illegal", 32'(illegal), 32'd1);
        chk("sticky_gap", 32'(gaps[1]), 32'd4);
        chk("sticky_pc", 32'(pc), 32'd2);

        // reset asserted during st EX1
        do_reset(vecs[2].prog);
        start_run();
        wait_done("rst_mid", 2, 1'b0);
        wait_state("rst_mid_ex1", 3'd4);
        Resetn = 1'b0;
        #1;
        chk("rst_mid_wren", 32'(mem_wren), 32'd0);
        chk("rst_mid_done", 32'(Done), 32'd0);
        chk("rst_mid_tstep", 32'(Tstep), 32'd0);
        chk("rst_mid_pc", 32'(pc), 32'd0);
        chk("rst_mid_count", 32'(instr_count), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mid_bus", 32'(BusWires), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_wren", 32'(wren_cnt), 32'd0);
        Resetn = 1'b1;
        start_run();
        wait_done("restart", 4, 1'b1);
        repeat (3) @(negedge clk);
        chk("restart_r5", 32'(dut.regs[5]), 32'hABCD);
        chk("restart_pc", 32'(pc), 32'd6);
        chk("restart_count", 32'(instr_count), 32'd4);
        chk("restart_wren", 32'(wren_cnt), 32'd1);

        // Run dropped in the middle of an add
        do_reset(vecs[0].prog);
        start_run();
        wait_done("run_low", 2, 1'b0);
        wait_state("run_low_ex2", 3'd5);
        Run = 1'b0;
        wait_done("run_low_finish", 3, 1'b0);
        repeat (2) @(negedge clk);
        chk("run_low_idle", 32'(Tstep), 32'd0);
        chk("run_low_r0", 32'(dut.regs[0]), 32'd8);
        chk("run_low_pc", 32'(pc), 32'd5);
        repeat (10) @(negedge clk);
        chk("run_low_pc_hold", 32'(pc), 32'd5);
        chk("run_low_count", 32'(instr_count), 32'd3);
        Run = 1'b1;
        wait_done("run_resume", 4, 1'b1);
        repeat (3) @(negedge clk);
        chk("run_resume_pc", 32'(pc), 32'd6);
        chk("run_resume_count", 32'(instr_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
